bram_port_arbiter: RTL and testbench

- Shares one 16x4096 simple-dual-port block RAM (one write port, one synchronous read port with 1-cycle read latency) between two requesters, e.g. CPU bus bridge (req0) and PPU/DMA engine (req1).
- Valid/ready handshake per requester. Returns read data with a fixed one-cycle response.
- Sits between the requesters and the BRAM instance. Drives all BRAM address, data and enable inputs.

---
 rtl/bram_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one simple-dual-port BRAM (one write port, one
// registered read port with 1-cycle latency) between two requesters.
// The read port and the write port are arbitrated independently. When both
// requesters want the same port, a single shared round-robin pointer picks
// the winner.
//
// Optional feature: define BRAM_ARB_CLEAR_EN to sweep the whole BRAM with
// CLEAR_VALUE after every reset. busy is high and no grants are issued
// during the sweep.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid/write/addr/wdata  request from requester N (N = 0, 1)
//   reqN_ready                request N accepted this cycle (combinational)
//   rspN_valid/data           read response, one cycle after the read grant
//   busy                      clear sweep in progress
//   bram_write_*              BRAM write port (driven combinationally)
//   bram_read_addr            BRAM read address (driven combinationally)
//   bram_read_data            BRAM registered read data
module bram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bram_write_addr,
  output logic [DATA_WIDTH-1:0] bram_write_data,
  output logic                  bram_write_enable,
  output logic [ADDR_WIDTH-1:0] bram_read_addr,
  input  logic [DATA_WIDTH-1:0] bram_read_data
);

  logic                  run;         // grants permitted this cycle
  logic                  sweep_we;    // clear sweep owns the write port
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [DATA_WIDTH-1:0] sweep_data;

`ifdef BRAM_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clear_addr;

  // Clear sweep: one word per cycle, then hand the BRAM to the requesters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clear_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clear_addr <= clear_addr + 1'b1;
      if (clear_addr == '1) state <= ST_RUN;
    end
  end

  assign busy       = (state == ST_CLEAR);
  assign run        = !rst && (state == ST_RUN);
  assign sweep_we   = !rst && (state == ST_CLEAR);
  assign sweep_addr = clear_addr;
`else
  assign busy       = 1'b0;
  assign run        = !rst;
  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
`endif

  assign sweep_data = CLEAR_VALUE;

  logic                  rr_ptr;      // 0: req0 wins the next conflict
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic want_w0, want_w1, want_r0, want_r1;
  logic gnt_w0, gnt_w1, gnt_r0, gnt_r1;
  logic conflict;

  // Per-port arbitration; a requester only ever wants one port at a time
  always_comb begin
    want_w0  = req0_valid &&  req0_write;
    want_r0  = req0_valid && !req0_write;
    want_w1  = req1_valid &&  req1_write;
    want_r1  = req1_valid && !req1_write;
    conflict = (want_w0 && want_w1) || (want_r0 && want_r1);
    gnt_w0   = run && want_w0 && (!want_w1 || !rr_ptr);
    gnt_w1   = run && want_w1 && (!want_w0 ||  rr_ptr);
    gnt_r0   = run && want_r0 && (!want_r1 || !rr_ptr);
    gnt_r1   = run && want_r1 && (!want_r0 ||  rr_ptr);
  end

  assign req0_ready = gnt_w0 || gnt_r0;
  assign req1_ready = gnt_w1 || gnt_r1;

  // Write port mux; address/data hold their last value when idle
  always_comb begin
    bram_write_enable = 1'b0;
    bram_write_addr   = wr_addr_q;
    bram_write_data   = wr_data_q;
    if (sweep_we) begin
      bram_write_enable = 1'b1;
      bram_write_addr   = sweep_addr;
      bram_write_data   = sweep_data;
    end else if (gnt_w0) begin
      bram_write_enable = 1'b1;
      bram_write_addr   = req0_addr;
      bram_write_data   = req0_wdata;
    end else if (gnt_w1) begin
      bram_write_enable = 1'b1;
      bram_write_addr   = req1_addr;
      bram_write_data   = req1_wdata;
    end
  end

  // Read port mux; address holds when no read is granted
  always_comb begin
    bram_read_addr = rd_addr_q;
    if (gnt_r0)      bram_read_addr = req0_addr;
    else if (gnt_r1) bram_read_addr = req1_addr;
  end

  // Responses share the BRAM data; only the valid flags are steered
  assign rsp0_data = bram_read_data;
  assign rsp1_data = bram_read_data;

  // Hold registers, response flags, and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      if (bram_write_enable) begin
        wr_addr_q <= bram_write_addr;
        wr_data_q <= bram_write_data;
      end
      rd_addr_q  <= bram_read_addr;
      rsp0_valid <= gnt_r0;
      rsp1_valid <= gnt_r1;
      // Whoever lost this conflict is favoured at the next one
      if (run && conflict) rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed bench for bram_port_arbiter with a
// behavioural read-first BRAM attached. Define BRAM_ARB_CLEAR_EN to also
// exercise the clear sweep (CLEAR_VALUE = 0xA5A5).
module tb_bram_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
`ifdef BRAM_ARB_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic          clk, rst;
  logic          req0_valid, req0_ready, req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_data;
  logic          req1_valid, req1_ready, req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_data;
  logic          busy;
  logic [AW-1:0] bram_write_addr;
  logic [DW-1:0] bram_write_data;
  logic          bram_write_enable;
  logic [AW-1:0] bram_read_addr;
  logic [DW-1:0] bram_read_data;

  int errors = 0;
  int checks = 0;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(16'hA5A5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .busy(busy),
    .bram_write_addr(bram_write_addr), .bram_write_data(bram_write_data),
    .bram_write_enable(bram_write_enable),
    .bram_read_addr(bram_read_addr), .bram_read_data(bram_read_data)
  );

  // Read-first simple-dual-port BRAM with registered read data
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_write_enable) mem[bram_write_addr] <= bram_write_data;
    bram_read_data <= mem[bram_read_addr];
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Uncontended write through requester 1 (leaves the pointer untouched)
  task automatic write1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, a, d);
    @(posedge clk);
    #1 idle();
  endtask

  // Bounded wait for the clear sweep to finish
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop", busy, 1'b0);
  endtask

`ifdef BRAM_ARB_CLEAR_EN
  // Called just after reset release; counts sweep cycles and checks each write
  task automatic sweep_run(output int n, output logic ok);
    n  = 0;
    ok = 1'b1;
    #1;
    while (busy && n < 5000) begin
      if (!(bram_write_enable && bram_write_addr == n[AW-1:0] &&
            bram_write_data == 16'hA5A5 && !req0_ready && !req1_ready)) ok = 1'b0;
      n++;
      @(negedge clk);
      #1;
    end
  endtask
`endif

  initial begin
    logic [3:0] exp_g0;
`ifdef BRAM_ARB_CLEAR_EN
    int   sn;
    logic sok;
`endif
    clk = 1'b0;
    rst = 1'b1;
    // Requests presented during reset must not be granted
    drive(1'b1, 1'b0, 12'h005, 16'h0, 1'b1, 1'b1, 12'h006, 16'h1);
    @(negedge clk);
    #1;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_rsp0", rsp0_valid, 1'b0);
    chk("rst_rsp1", rsp1_valid, 1'b0);
    chk("rst_we", bram_write_enable, 1'b0);
    chk("rst_busy", busy, BUSY_RST);
    idle();
    @(negedge clk);
    rst = 1'b0;

`ifdef BRAM_ARB_CLEAR_EN
    drive(1'b1, 1'b0, 12'h000, 16'h0, 1'b1, 1'b1, 12'h005, 16'h7);
    sweep_run(sn, sok);
    chk("sweep_len", sn, 4096);
    chk("sweep_ok", sok, 1'b1);
    idle();
    @(negedge clk);
    drive(1'b1, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    drive(1'b1, 1'b0, 12'h7FF, 16'h0, 1'b0, 1'b0, '0, '0);
    #1 chk("clr_rd000", {rsp0_valid, rsp0_data}, {1'b1, 16'hA5A5});
    @(negedge clk);
    drive(1'b1, 1'b0, 12'hFFF, 16'h0, 1'b0, 1'b0, '0, '0);
    #1 chk("clr_rd7ff", {rsp0_valid, rsp0_data}, {1'b1, 16'hA5A5});
    @(negedge clk);
    idle();
    #1 chk("clr_rdfff", {rsp0_valid, rsp0_data}, {1'b1, 16'hA5A5});
    // Reset at sweep address 100 restarts the sweep from 0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sn = 0;
    #1;
    while (bram_write_addr != 12'd100 && sn < 200) begin
      @(negedge clk);
      #1;
      sn++;
    end
    chk("clr_at100", bram_write_addr, 12'd100);
    rst = 1'b1;
    #1 chk("clr_rst_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    sweep_run(sn, sok);
    chk("resweep_len", sn, 4096);
    chk("resweep_ok", sok, 1'b1);
    wait_idle();
`endif

    // Test 1: write then read back through requester 0
    @(negedge clk);
    drive(1'b1, 1'b1, 12'h010, 16'hBEEF, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t1_wr_ready", req0_ready, 1'b1);
    chk("t1_we", bram_write_enable, 1'b1);
    chk("t1_waddr", bram_write_addr, 12'h010);
    chk("t1_wdata", bram_write_data, 16'hBEEF);
    @(negedge clk);
    drive(1'b1, 1'b0, 12'h010, 16'h0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t1_rd_ready", req0_ready, 1'b1);
    chk("t1_raddr", bram_read_addr, 12'h010);
    chk("t1_we_idle", bram_write_enable, 1'b0);
    chk("t1_waddr_hold", bram_write_addr, 12'h010);
    chk("t1_rsp_early", rsp0_valid, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk("t1_rsp0_valid", rsp0_valid, 1'b1);
    chk("t1_rsp0_data", rsp0_data, 16'hBEEF);
    chk("t1_rsp1_quiet", rsp1_valid, 1'b0);
    @(negedge clk);
    #1 chk("t1_rsp0_once", rsp0_valid, 1'b0);

    // Test 2: both read every cycle; grants alternate 0,1,0,1
    write1(12'h001, 16'h1111);
    write1(12'h002, 16'h2222);
    exp_g0 = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 12'h001, 16'h0, 1'b1, 1'b0, 12'h002, 16'h0);
      #1;
      chk("t2_ready0", req0_ready, exp_g0[k]);
      chk("t2_ready1", req1_ready, !exp_g0[k]);
      if (k > 0) begin
        chk("t2_rsp0_valid", rsp0_valid, exp_g0[k-1]);
        chk("t2_rsp1_valid", rsp1_valid, !exp_g0[k-1]);
        chk("t2_rsp_data", exp_g0[k-1] ? rsp0_data : rsp1_data,
            exp_g0[k-1] ? 16'h1111 : 16'h2222);
      end
    end
    @(negedge clk);
    idle();
    #1;
    chk("t2_last_rsp1", {rsp0_valid, rsp1_valid, rsp1_data}, {2'b01, 16'h2222});

    // Test 3: same-cycle write and read of one address returns the old word
    write1(12'h020, 16'h5555);
    @(negedge clk);
    drive(1'b1, 1'b1, 12'h020, 16'h1234, 1'b1, 1'b0, 12'h020, 16'h0);
    #1;
    chk("t3_ready0", req0_ready, 1'b1);
    chk("t3_ready1", req1_ready, 1'b1);
    chk("t3_raddr", bram_read_addr, 12'h020);
    @(negedge clk);
    idle();
    #1;
    chk("t3_rsp1", {rsp0_valid, rsp1_valid, rsp1_data}, {2'b01, 16'h5555});
    @(negedge clk);
    drive(1'b1, 1'b0, 12'h020, 16'h0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    idle();
    #1 chk("t3_new_word", {rsp0_valid, rsp0_data}, {1'b1, 16'h1234});

    // Test 4: req1 back-to-back reads of addrs 0..7 holding 1..8
    for (int i = 0; i < 8; i++) write1(12'(i), 16'(i + 1));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'(i), 16'h0);
      else idle();
      #1;
      if (i < 8) chk("t4_ready1", req1_ready, 1'b1);
      if (i > 0) chk("t4_rsp1", {rsp1_valid, rsp1_data}, {1'b1, 16'(i)});
    end
    @(negedge clk);
    #1 chk("t4_rsp1_end", rsp1_valid, 1'b0);

    // Test 5: conflict leaves req1 favoured; reset mid-response restores req0
    @(negedge clk);
    drive(1'b1, 1'b1, 12'h030, 16'hAAAA, 1'b1, 1'b1, 12'h031, 16'hBBBB);
    #1;
    chk("t5_wconf", {req0_ready, req1_ready}, 2'b10);
    chk("t5_waddr", bram_write_addr, 12'h030);
    @(negedge clk);
    drive(1'b1, 1'b0, 12'h010, 16'h0, 1'b0, 1'b0, '0, '0);
    #1 chk("t5_rd_ready", req0_ready, 1'b1);
    @(posedge clk);
    #1 chk("t5_rsp_due", rsp0_valid, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 12'h001, 16'h0, 1'b1, 1'b0, 12'h002, 16'h0);
    #1;
    chk("t5_rst_rsp0", rsp0_valid, 1'b0);
    chk("t5_rst_ready", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    idle();
    rst = 1'b0;
    wait_idle();
    @(negedge clk);
    drive(1'b1, 1'b0, 12'h001, 16'h0, 1'b1, 1'b0, 12'h002, 16'h0);
    #1 chk("t5_ptr_reset", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
